// File: rtl/cd7_seq_mul8x8_if.sv
// Operand/result bundle for cd7_seq_mul8x8; err_out exists only when CD7_ERR_EN is defined.
// Both channels use valid/ready: a transfer happens on the rising edge where valid and ready are both 1, and the source holds its payload stable while valid=1 and ready=0.
interface cd7_seq_mul8x8_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p_out;
    logic        ovf_out;
`ifdef CD7_ERR_EN
    logic [15:0] err_out;

    modport master (output in_valid, a_in, b_in, out_ready,
                    input  in_ready, out_valid, p_out, ovf_out, err_out);
    modport slave  (input  in_valid, a_in, b_in, out_ready,
                    output in_ready, out_valid, p_out, ovf_out, err_out);
`else
    modport master (output in_valid, a_in, b_in, out_ready,
                    input  in_ready, out_valid, p_out, ovf_out);
    modport slave  (input  in_valid, a_in, b_in, out_ready,
                    output in_ready, out_valid, p_out, ovf_out);
`endif
endinterface

// File: rtl/cd7_seq_mul8x8.sv
// Sequential 8x8 approximate multiplier: one cd7 (8x4 carry-disregard) pass per B nibble.
// Optional macro CD7_ERR_EN adds err_out = |A*B - p_out| alongside the result.
module cd7_seq_mul8x8 #(
    parameter bit ZERO_SKIP = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cd7_seq_mul8x8_if.slave  bus,
    output logic [CNT_W-1:0] op_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  a_q, b_q;
    logic [16:0] acc, acc_nxt;
    logic [3:0]  nib;
    logic [11:0] r;
    logic        cap;
    logic        hs;

    // cd7: low 7 result columns OR the partial products (carries dropped),
    // upper columns 7..11 are summed exactly.
    function automatic logic [11:0] cd7(input logic [7:0] a, input logic [3:0] n);
        logic [10:0] pp0, pp1, pp2, pp3;
        logic [6:0]  lo;
        logic [4:0]  hi;
        pp0 = n[0] ? {3'b000, a}        : 11'd0;
        pp1 = n[1] ? {2'b00, a, 1'b0}   : 11'd0;
        pp2 = n[2] ? {1'b0, a, 2'b00}   : 11'd0;
        pp3 = n[3] ? {a, 3'b000}        : 11'd0;
        lo  = pp0[6:0] | pp1[6:0] | pp2[6:0] | pp3[6:0];
        hi  = {1'b0, pp0[10:7]} + {1'b0, pp1[10:7]} + {1'b0, pp2[10:7]} + {1'b0, pp3[10:7]};
        return {hi, lo};
    endfunction

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cap       = 1'b0;
        hs        = 1'b0;
        nib       = (state == LO) ? b_q[3:0] : b_q[7:4];
        r         = cd7(a_q, nib);
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    cap     = 1'b1;
                    acc_nxt = '0;
                    if (ZERO_SKIP && bus.b_in == 8'h00)
                        state_nxt = DONE;
                    else if (ZERO_SKIP && bus.b_in[3:0] == 4'h0)
                        state_nxt = HI;
                    else
                        state_nxt = LO;
                end
            end
            LO: begin
                acc_nxt   = {5'b0, r};
                state_nxt = (ZERO_SKIP && b_q[7:4] == 4'h0) ? DONE : HI;
            end
            HI: begin
                acc_nxt   = acc + {1'b0, r, 4'b0000};
                state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    hs        = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            op_cnt <= '0;
        end else begin
            if (cap) begin
                a_q <= bus.a_in;
                b_q <= bus.b_in;
            end
            acc <= acc_nxt;
            if (hs) op_cnt <= op_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.p_out     = acc[15:0];
    assign bus.ovf_out   = acc[16];
    assign dbg_state     = state;

`ifdef CD7_ERR_EN
    logic [7:0]  ea, eb;
    logic [15:0] exact, err_q, err_nxt;

    // B==0 jumps to DONE on the accept edge, before the operand registers load.
    assign ea      = cap ? bus.a_in : a_q;
    assign eb      = cap ? bus.b_in : b_q;
    assign exact   = {8'h00, ea} * {8'h00, eb};
    assign err_nxt = (exact >= acc_nxt[15:0]) ? (exact - acc_nxt[15:0]) : (acc_nxt[15:0] - exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else if (state_nxt == DONE && state != DONE)
            err_q <= err_nxt;
    end

    assign bus.err_out = err_q;
`endif

endmodule

// File: tb/tb_cd7_seq_mul8x8.sv
// Bench for cd7_seq_mul8x8: ZERO_SKIP=1 (16-bit counter) and ZERO_SKIP=0 (4-bit counter) instances
// driven in turn and checked every cycle against a transaction-level model.
module tb_cd7_seq_mul8x8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cd7_seq_mul8x8_if bus0 ();
    cd7_seq_mul8x8_if bus1 ();

    logic [15:0] op_cnt0;
    logic [3:0]  op_cnt1;
    logic [1:0]  dbg0, dbg1;

    cd7_seq_mul8x8 #(.ZERO_SKIP(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .op_cnt(op_cnt0), .dbg_state(dbg0));
    cd7_seq_mul8x8 #(.ZERO_SKIP(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .op_cnt(op_cnt1), .dbg_state(dbg1));

    logic       iv[2];
    logic [7:0] a_d[2], b_d[2];
    logic       ordy[2];
    logic       ir[2], ov[2], ovf[2];
    logic [15:0] p[2], cnt[2];

    assign bus0.in_valid  = iv[0];
    assign bus0.a_in      = a_d[0];
    assign bus0.b_in      = b_d[0];
    assign bus0.out_ready = ordy[0];
    assign bus1.in_valid  = iv[1];
    assign bus1.a_in      = a_d[1];
    assign bus1.b_in      = b_d[1];
    assign bus1.out_ready = ordy[1];
    assign ir[0]  = bus0.in_ready;
    assign ir[1]  = bus1.in_ready;
    assign ov[0]  = bus0.out_valid;
    assign ov[1]  = bus1.out_valid;
    assign ovf[0] = bus0.ovf_out;
    assign ovf[1] = bus1.ovf_out;
    assign p[0]   = bus0.p_out;
    assign p[1]   = bus1.p_out;
    assign cnt[0] = op_cnt0;
    assign cnt[1] = {12'h000, op_cnt1};
`ifdef CD7_ERR_EN
    logic [15:0] er[2];
    assign er[0] = bus0.err_out;
    assign er[1] = bus1.err_out;
`endif

    int errors = 0;
    int checks = 0;
    int tocnt  = 0;
    bit done   = 1'b0;

    // ---------------- reference model ----------------
    function automatic int cd7_ref(input int a, input int n);
        int lo = 0;
        int hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (((n >> i) & 1) != 0) begin
                lo = lo | ((a << i) % 128);
                hi = hi + ((a << i) / 128);
            end
        end
        return hi * 128 + lo;
    endfunction

    function automatic int gold(input int a, input int b);
        return cd7_ref(a, b % 16) + 16 * cd7_ref(a, b / 16);
    endfunction

    function automatic int lat_of(input bit zs, input int b);
        if (!zs)                            return 3;
        if (b == 0)                         return 1;
        if ((b % 16) == 0 || (b / 16) == 0) return 2;
        return 3;
    endfunction

    function automatic int abs_err(input int a, input int b);
        int d;
        d = a * b - (gold(a, b) % 65536);
        return (d < 0) ? -d : d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_op(input int s, input logic [7:0] a, input logic [7:0] b, input int hold);
        int n;
        @(posedge clk); #1;
        iv[s] = 1'b1; a_d[s] = a; b_d[s] = b; ordy[s] = (hold == 0);
        n = 0;
        forever begin
            @(negedge clk);
            if (ir[s]) break;
            n++;
            if (n > 20) begin tocnt++; break; end
        end
        @(posedge clk); #1;
        iv[s] = 1'b0; a_d[s] = 8'($urandom); b_d[s] = 8'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            if (ov[s]) break;
            n++;
            if (n > 10) begin tocnt++; break; end
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 ordy[s] = 1'b1;
        end
        @(posedge clk); #1;
        ordy[s] = 1'b0;
    endtask

    task automatic rst_mid(input int s);
        int n;
        @(posedge clk); #1;
        iv[s] = 1'b1; a_d[s] = 8'hFF; b_d[s] = 8'h11; ordy[s] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ir[s]) break;
            n++;
            if (n > 20) begin tocnt++; break; end
        end
        @(posedge clk); #1 iv[s] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ordy[s] = 1'b0;
    endtask

    initial begin : driver
        logic [7:0] a, b;
        int hold;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; a_d[s] = 8'h00; b_d[s] = 8'h00; ordy[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            do_op(s, 8'hFF, 8'h11, 0);
            do_op(s, 8'h80, 8'h10, 0);
            do_op(s, 8'h80, 8'h00, 0);
            do_op(s, 8'h01, 8'h81, 5);
            rst_mid(s);
            do_op(s, 8'h02, 8'h01, 0);
            for (int i = 0; i < 2500; i++) begin
                a = 8'($urandom);
                case ($urandom_range(0, 7))
                    0:       b = 8'h00;
                    1:       b = 8'($urandom_range(0, 15)) << 4;
                    2:       b = 8'($urandom_range(0, 15));
                    default: b = 8'($urandom);
                endcase
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                if ($urandom_range(0, 1) == 1) @(posedge clk);
                do_op(s, a, b, hold);
            end
        end
        repeat (3) @(posedge clk);
        done = 1'b1;
    end

    // ---------------- scoreboard / compare ----------------
    bit          pend[2];
    int          acc_k[2], lat[2], cm[2];
    logic [16:0] ep[2];
    logic [15:0] ee[2];

    initial begin : compare
        int  k;
        bit  eov;
        chk("pin_cd7_ff_f",  32'(cd7_ref(255, 15)), 32'h0D7F);
        chk("pin_cd7_3_3",   32'(cd7_ref(3, 3)),    32'h0007);
        chk("pin_gold_ff11", 32'(gold(255, 17)),    32'h10EF);
        chk("pin_gold_8010", 32'(gold(128, 16)),    32'h0800);
        chk("pin_gold_0181", 32'(gold(1, 129)),     32'h0081);
        chk("pin_gold_0201", 32'(gold(2, 1)),       32'h0002);
        chk("pin_lat_zs_hi", 32'(lat_of(1'b1, 16)), 32'd2);
        chk("pin_lat_zs_0",  32'(lat_of(1'b1, 0)),  32'd1);
        chk("pin_lat_nozs",  32'(lat_of(1'b0, 0)),  32'd3);
        chk("pin_err_3x3",   32'(abs_err(3, 3)),    32'd2);
        for (int s = 0; s < 2; s++) begin
            pend[s] = 1'b0; acc_k[s] = 0; lat[s] = 0; cm[s] = 0; ep[s] = '0; ee[s] = '0;
        end
        k = 0;
        while (!done && k < 90000) begin
            @(negedge clk);
            k++;
            for (int s = 0; s < 2; s++) begin
                if (!rst_n) begin
                    chk($sformatf("u%0d_rst_out_valid", s), 32'(ov[s]),  32'd0);
                    chk($sformatf("u%0d_rst_in_ready", s),  32'(ir[s]),  32'd1);
                    chk($sformatf("u%0d_rst_p_out", s),     32'(p[s]),   32'd0);
                    chk($sformatf("u%0d_rst_ovf", s),       32'(ovf[s]), 32'd0);
                    chk($sformatf("u%0d_rst_op_cnt", s),    32'(cnt[s]), 32'd0);
`ifdef CD7_ERR_EN
                    chk($sformatf("u%0d_rst_err", s),       32'(er[s]),  32'd0);
`endif
                    pend[s] = 1'b0;
                    cm[s]   = 0;
                end else begin
                    eov = pend[s] && (k >= acc_k[s] + lat[s]);
                    chk($sformatf("u%0d_in_ready", s),  32'(ir[s]), 32'(!pend[s]));
                    chk($sformatf("u%0d_out_valid", s), 32'(ov[s]), 32'(eov));
                    chk($sformatf("u%0d_op_cnt", s),    32'(cnt[s]),
                        (s == 0) ? 32'(cm[s] % 65536) : 32'(cm[s] % 16));
                    if (eov) begin
                        chk($sformatf("u%0d_p_out", s),   32'(p[s]),   32'(ep[s][15:0]));
                        chk($sformatf("u%0d_ovf_out", s), 32'(ovf[s]), 32'(ep[s][16]));
`ifdef CD7_ERR_EN
                        chk($sformatf("u%0d_err_out", s), 32'(er[s]),  32'(ee[s]));
`endif
                    end
                    if (!pend[s] && iv[s]) begin
                        pend[s]  = 1'b1;
                        acc_k[s] = k;
                        lat[s]   = lat_of(s == 0, int'(b_d[s]));
                        ep[s]    = 17'(gold(int'(a_d[s]), int'(b_d[s])));
                        ee[s]    = 16'(abs_err(int'(a_d[s]), int'(b_d[s])));
                    end else if (eov && ordy[s]) begin
                        pend[s] = 1'b0;
                        cm[s]++;
                    end
                end
            end
        end
        chk("run_finished", 32'(done), 32'd1);
        chk("wait_timeouts", 32'(tocnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
